// File: rtl/traffic_phase_ctrl_if.sv
// Bundle of the phase sequencer's strobes, config bus and display/pedestrian outputs.
// The master drives tick/ped/config and the slave (the sequencer) drives the outputs.
interface traffic_phase_ctrl_if;
  logic       tick;
  logic       ped_req;
  logic       cfg_we;
  logic [1:0] cfg_sel;
  logic [3:0] cfg_data;
  logic [1:0] state;
  logic [3:0] count_down;
  logic [2:0] light;
  logic       ped_walk;
  logic       ped_ack;
  logic       phase_done;

  modport master (
    output tick, ped_req, cfg_we, cfg_sel, cfg_data,
    input  state, count_down, light, ped_walk, ped_ack, phase_done
  );

  modport slave (
    input  tick, ped_req, cfg_we, cfg_sel, cfg_data,
    output state, count_down, light, ped_walk, ped_ack, phase_done
  );
endinterface

// File: rtl/traffic_phase_ctrl.sv
// Traffic-light phase sequencer: GREEN -> YELLOW -> RED -> ALL_RED, tick-driven countdown,
// pedestrian request latch with green truncation, and programmable phase durations.
module traffic_phase_ctrl #(
  parameter logic [3:0] G_DUR   = 4'd15,
  parameter logic [3:0] Y_DUR   = 4'd5,
  parameter logic [3:0] R_DUR   = 4'd10,
  parameter logic [3:0] AR_DUR  = 4'd1,
  parameter logic [3:0] PED_CUT = 4'd3
) (
  input  logic                 clk,
  input  logic                 reset,
  traffic_phase_ctrl_if.slave  bus
);

  localparam logic [1:0] S_GREEN   = 2'd0;
  localparam logic [1:0] S_YELLOW  = 2'd1;
  localparam logic [1:0] S_RED     = 2'd2;
  localparam logic [1:0] S_ALL_RED = 2'd3;

  logic [1:0] state_q;
  logic [1:0] next_state;
  logic [3:0] count_q;
  logic [3:0] next_count;
  logic [2:0] light_q;
  logic [2:0] next_light;
  logic       walk_q;
  logic       ack_q;
  logic       done_q;
  logic       ped_pend;
  logic       advance;
  logic       enter_red;
  logic [3:0] g_dur_q;
  logic [3:0] y_dur_q;
  logic [3:0] r_dur_q;

  // Duration registers are read before this cycle's write lands, so a
  // same-cycle write and reload always loads the old value.
  always_comb begin
    advance    = bus.tick && (count_q == 4'd0);
    enter_red  = advance && (state_q == S_YELLOW);
    next_state = state_q;
    next_count = count_q;
    if (bus.tick) begin
      if (count_q == 4'd0) begin
        next_state = state_q + 2'd1;
        case (state_q)
          S_GREEN:  next_count = y_dur_q;
          S_YELLOW: next_count = r_dur_q;
          S_RED:    next_count = AR_DUR;
          default:  next_count = g_dur_q;
        endcase
      end else if ((state_q == S_GREEN) && ped_pend && (count_q > PED_CUT)) begin
        next_count = PED_CUT;
      end else begin
        next_count = count_q - 4'd1;
      end
    end
    case (next_state)
      S_GREEN:  next_light = 3'b001;
      S_YELLOW: next_light = 3'b010;
      default:  next_light = 3'b100;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_GREEN;
      count_q  <= G_DUR;
      light_q  <= 3'b001;
      walk_q   <= 1'b0;
      ack_q    <= 1'b0;
      done_q   <= 1'b0;
      ped_pend <= 1'b0;
      g_dur_q  <= G_DUR;
      y_dur_q  <= Y_DUR;
      r_dur_q  <= R_DUR;
    end else begin
      state_q  <= next_state;
      count_q  <= next_count;
      light_q  <= next_light;
      walk_q   <= (next_state == S_RED);
      done_q   <= advance;
      // A request arriving on the RED entry cycle is served by that entry.
      ack_q    <= enter_red && (ped_pend || bus.ped_req);
      ped_pend <= enter_red ? 1'b0 : (ped_pend || bus.ped_req);
      if (bus.cfg_we) begin
        case (bus.cfg_sel)
          2'd0:    g_dur_q <= bus.cfg_data;
          2'd1:    y_dur_q <= bus.cfg_data;
          2'd2:    r_dur_q <= bus.cfg_data;
          default: ;
        endcase
      end
    end
  end

  assign bus.state      = state_q;
  assign bus.count_down = count_q;
  assign bus.light      = light_q;
  assign bus.ped_walk   = walk_q;
  assign bus.ped_ack    = ack_q;
  assign bus.phase_done = done_q;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Self-checking bench for traffic_phase_ctrl: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a phase-level model.
module tb_traffic_phase_ctrl;

  logic clk = 1'b0;
  logic reset;
  traffic_phase_ctrl_if bus ();

  traffic_phase_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int tally[4];
  int ack_seen  = 0;
  int done_seen = 0;
  int base;
  bit model_valid = 1'b0;

  // Model state: phase index, ticks remaining, duration table, pending request.
  int m_phase;
  int m_cnt;
  int m_dur[3];
  bit m_pend;
  bit m_ack;
  bit m_done;
  int lamp[4] = '{1, 2, 4, 4};

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      if (reset) begin
        m_phase = 0; m_cnt = 15; m_dur = '{15, 5, 10}; m_pend = 0;
        m_ack = 0; m_done = 0; model_valid = 1'b1;
      end else if (model_valid) begin
        int  nd[3];
        bit  entering;
        nd = m_dur;
        if (bus.cfg_we && bus.cfg_sel != 2'd3) nd[bus.cfg_sel] = int'(bus.cfg_data);
        entering = 0;
        m_done   = 0;
        m_ack    = 0;
        if (bus.tick) begin
          if (m_cnt == 0) begin
            m_phase  = (m_phase + 1) % 4;
            m_cnt    = (m_phase == 3) ? 1 : m_dur[m_phase];
            m_done   = 1;
            entering = (m_phase == 2);
          end else if (m_phase == 0 && m_pend && m_cnt > 3) begin
            m_cnt = 3;
          end else begin
            m_cnt = m_cnt - 1;
          end
        end
        if (entering) begin
          m_ack  = m_pend || bus.ped_req;
          m_pend = 0;
        end else if (bus.ped_req) begin
          m_pend = 1;
        end
        m_dur = nd;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (model_valid && !reset) begin
        check("state",      int'(bus.state),      m_phase);
        check("count_down", int'(bus.count_down), m_cnt);
        check("light",      int'(bus.light),      lamp[m_phase]);
        check("ped_walk",   int'(bus.ped_walk),   int'(m_phase == 2));
        check("ped_ack",    int'(bus.ped_ack),    int'(m_ack));
        check("phase_done", int'(bus.phase_done), int'(m_done));
        if (bus.ped_ack === 1'b1) ack_seen++;
        if (bus.phase_done === 1'b1) done_seen++;
      end
    end
  end

  task automatic next_clk();
    @(posedge clk);
    #2;
  endtask

  task automatic do_tick();
    tally[bus.state]++;
    bus.tick = 1'b1;
    next_clk();
    bus.tick = 1'b0;
    repeat (3) next_clk();
  endtask

  task automatic pulse_req();
    bus.ped_req = 1'b1;
    next_clk();
    bus.ped_req = 1'b0;
  endtask

  task automatic run_until(input logic [1:0] target);
    int n = 0;
    while (bus.state != target && n < 100) begin
      do_tick();
      n++;
    end
    if (bus.state != target) check("run_until_timeout", int'(bus.state), int'(target));
  endtask

  task automatic clear_tally();
    for (int i = 0; i < 4; i++) tally[i] = 0;
  endtask

  initial begin
    bus.tick = 0; bus.ped_req = 0; bus.cfg_we = 0; bus.cfg_sel = 0; bus.cfg_data = 0;
    reset = 1'b1;
    #2;
    // Reset collides with tick, ped_req and a config write.
    bus.tick = 1; bus.ped_req = 1; bus.cfg_we = 1; bus.cfg_sel = 0; bus.cfg_data = 7;
    repeat (2) next_clk();
    reset = 1'b0;
    bus.tick = 0; bus.ped_req = 0; bus.cfg_we = 0;
    next_clk();
    check("reset_state", int'(bus.state), 0);
    check("reset_count", int'(bus.count_down), 15);
    check("reset_light", int'(bus.light), 1);
    check("reset_walk",  int'(bus.ped_walk), 0);

    clear_tally();
    base = done_seen;
    repeat (35) do_tick();
    check("free_green_ticks",   tally[0], 16);
    check("free_yellow_ticks",  tally[1], 6);
    check("free_red_ticks",     tally[2], 11);
    check("free_allred_ticks",  tally[3], 2);
    check("free_done_pulses",   done_seen - base, 4);
    check("free_wrap_count",    int'(bus.count_down), 15);

    repeat (3) do_tick();
    check("ped_pre_count", int'(bus.count_down), 12);
    pulse_req();
    do_tick();
    check("ped_trunc_count", int'(bus.count_down), 3);
    repeat (3) do_tick();
    check("ped_count_zero", int'(bus.count_down), 0);
    do_tick();
    check("ped_to_yellow", int'(bus.state), 1);
    base = ack_seen;
    run_until(2'd2);
    check("ped_ack_pulses", ack_seen - base, 1);
    clear_tally();
    run_until(2'd3);
    check("ped_walk_ticks", tally[2], 11);
    run_until(2'd0);

    repeat (13) do_tick();
    check("late_pre_count", int'(bus.count_down), 2);
    pulse_req();
    do_tick();
    check("late_no_trunc", int'(bus.count_down), 1);
    base = ack_seen;
    run_until(2'd2);
    check("late_ack_pulses", ack_seen - base, 1);

    repeat (5) do_tick();
    check("red_req_count", int'(bus.count_down), 5);
    pulse_req();
    base = ack_seen;
    run_until(2'd0);
    check("red_req_no_ack", ack_seen - base, 0);
    check("red_req_green_load", int'(bus.count_down), 15);
    do_tick();
    check("red_req_trunc", int'(bus.count_down), 3);
    base = ack_seen;
    run_until(2'd2);
    check("red_req_next_ack", ack_seen - base, 1);

    run_until(2'd1);
    clear_tally();
    do_tick();
    bus.cfg_we = 1; bus.cfg_sel = 1; bus.cfg_data = 2;
    next_clk();
    bus.cfg_sel = 3; bus.cfg_data = 0;
    next_clk();
    bus.cfg_we = 0;
    run_until(2'd2);
    check("cfg_old_yellow", tally[1], 6);
    run_until(2'd1);
    clear_tally();
    run_until(2'd2);
    check("cfg_new_yellow", tally[1], 3);
    clear_tally();
    run_until(2'd0);
    check("cfg_sel3_red",    tally[2], 11);
    check("cfg_sel3_allred", tally[3], 2);

    run_until(2'd3);
    do_tick();
    check("coll_allred_zero", int'(bus.count_down), 0);
    bus.cfg_we = 1; bus.cfg_sel = 0; bus.cfg_data = 5;
    tally[bus.state]++;
    bus.tick = 1;
    next_clk();
    bus.tick = 0; bus.cfg_we = 0;
    repeat (3) next_clk();
    check("coll_old_green", int'(bus.count_down), 15);
    clear_tally();
    run_until(2'd1);
    check("coll_green_ticks", tally[0], 16);
    run_until(2'd0);
    check("coll_new_green", int'(bus.count_down), 5);

    for (int i = 0; i < 4000; i++) begin
      bus.tick     = ($urandom_range(0, 2) == 0);
      bus.ped_req  = ($urandom_range(0, 11) == 0);
      bus.cfg_we   = ($urandom_range(0, 19) == 0);
      bus.cfg_sel  = 2'($urandom_range(0, 3));
      bus.cfg_data = 4'($urandom_range(0, 15));
      reset        = ($urandom_range(0, 499) == 0);
      next_clk();
    end
    bus.tick = 0; bus.ped_req = 0; bus.cfg_we = 0; reset = 0;
    repeat (2) next_clk();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
